// File: rtl/block_sequencer_pkg.sv
// Shared types and default sizing for the per-core block sequencer.
package block_sequencer_pkg;

  localparam int unsigned DefThreadsPerBlock = 4;
  localparam int unsigned DefPcBits          = 8;
  localparam int unsigned DefInstrBits       = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StRequest = 3'd3,
    StWait    = 3'd4,
    StExecute = 3'd5,
    StUpdate  = 3'd6,
    StDone    = 3'd7
  } state_t;

endpackage

// File: rtl/block_sequencer_if.sv
// Dispatch, instruction-fetch, decode and LSU signals seen by one core's sequencer.
interface block_sequencer_if
  import block_sequencer_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = DefThreadsPerBlock,
  parameter int unsigned PC_BITS           = DefPcBits,
  parameter int unsigned INSTR_BITS        = DefInstrBits
);

  localparam int unsigned TcBits = $clog2(THREADS_PER_BLOCK) + 1;

  logic                         start;
  logic [7:0]                   block_id;
  logic [TcBits-1:0]            thread_count;
  logic                         done;
  logic [THREADS_PER_BLOCK-1:0] thread_enable;
  logic [7:0]                   latched_block_id;
  logic [2:0]                   core_state;
  logic [PC_BITS-1:0]           pc;
  logic                         imem_req;
  logic [PC_BITS-1:0]           imem_addr;
  logic                         imem_ack;
  logic [INSTR_BITS-1:0]        imem_data;
  logic [INSTR_BITS-1:0]        instruction;
  logic                         decoded_mem;
  logic                         decoded_ret;
  logic                         branch_taken;
  logic [PC_BITS-1:0]           branch_target;
  logic                         lsu_req;
  logic [THREADS_PER_BLOCK-1:0] lsu_done;

  modport master (
    input  start, block_id, thread_count, imem_ack, imem_data,
    input  decoded_mem, decoded_ret, branch_taken, branch_target, lsu_done,
    output done, thread_enable, latched_block_id, core_state, pc,
    output imem_req, imem_addr, instruction, lsu_req
  );

  modport slave (
    output start, block_id, thread_count, imem_ack, imem_data,
    output decoded_mem, decoded_ret, branch_taken, branch_target, lsu_done,
    input  done, thread_enable, latched_block_id, core_state, pc,
    input  imem_req, imem_addr, instruction, lsu_req
  );

endinterface

// File: rtl/block_sequencer_lsu_pending_tracker.sv
// Tracks which enabled threads still owe an LSU completion for the current instruction.
module lsu_pending_tracker #(
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [THREADS_PER_BLOCK-1:0] load_mask,
  input  logic                         clear_en,
  input  logic [THREADS_PER_BLOCK-1:0] lsu_done,
  output logic                         all_clear
);

  logic [THREADS_PER_BLOCK-1:0] pending_q;

  // Load wins over clear, so completions arriving alongside the load are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
    end else if (load) begin
      pending_q <= load_mask;
    end else if (clear_en) begin
      pending_q <= pending_q & ~lsu_done;
    end
  end

  assign all_clear = (pending_q == '0);

endmodule

// File: rtl/block_sequencer.sv
// Core-side block sequencer: walks each instruction through fetch..update until RET.
module block_sequencer
  import block_sequencer_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = DefThreadsPerBlock,
  parameter int unsigned PC_BITS           = DefPcBits,
  parameter int unsigned INSTR_BITS        = DefInstrBits
) (
  input logic               clk,
  input logic               reset,
  block_sequencer_if.master bus
);

  state_t                       state_q;
  logic                         done_q;
  logic [THREADS_PER_BLOCK-1:0] enable_q;
  logic [7:0]                   block_id_q;
  logic [PC_BITS-1:0]           pc_q;
  logic                         imem_req_q;
  logic [INSTR_BITS-1:0]        instr_q;
  logic [THREADS_PER_BLOCK-1:0] start_mask;
  logic                         all_clear;

  // Thread counts above the core width saturate to all threads.
  always_comb begin
    start_mask = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      start_mask[i] = (i < 32'(bus.thread_count));
    end
  end

  lsu_pending_tracker #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK)
  ) u_pending (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == StRequest),
    .load_mask (bus.decoded_mem ? enable_q : '0),
    .clear_en  (state_q == StWait),
    .lsu_done  (bus.lsu_done),
    .all_clear (all_clear)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      enable_q   <= '0;
      block_id_q <= '0;
      pc_q       <= '0;
      imem_req_q <= 1'b0;
      instr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            block_id_q <= bus.block_id;
            enable_q   <= start_mask;
            pc_q       <= '0;
            if (bus.thread_count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StFetch;
              imem_req_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (bus.imem_ack) begin
            instr_q    <= bus.imem_data;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode:  state_q <= StRequest;
        StRequest: state_q <= StWait;
        StWait: begin
          if (all_clear) begin
            state_q <= StExecute;
          end
        end
        StExecute: state_q <= StUpdate;
        StUpdate: begin
          if (bus.decoded_ret) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            pc_q       <= bus.branch_taken ? bus.branch_target : pc_q + PC_BITS'(1);
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end
        end
        // Terminal until reset; start is no longer looked at.
        StDone: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.done             = done_q;
  assign bus.thread_enable    = enable_q;
  assign bus.latched_block_id = block_id_q;
  assign bus.core_state       = state_q;
  assign bus.pc               = pc_q;
  assign bus.imem_req         = imem_req_q;
  assign bus.imem_addr        = pc_q;
  assign bus.instruction      = instr_q;
  // Decode is only valid from REQUEST, so the launch pulse is qualified by state.
  assign bus.lsu_req          = (state_q == StRequest) && bus.decoded_mem;

endmodule

// File: doc/block_sequencer.md
Name: block_sequencer

Overview:
- Core-side end of the block-dispatch handshake. One instance per compute core.
- Accepts a block assignment (start, block_id, thread_count) from the top-level dispatcher.
- Sequences the core through fetch/decode/request/wait/execute/update for every instruction of the kernel.
- Raises done when the block executes RET. Also drives the per-thread enable mask, instruction-memory request and LSU request/completion tracking for the core.

Parameters:
THREADS_PER_BLOCK, 4, max threads per core; thread_count width is $clog2(THREADS_PER_BLOCK)+1
PC_BITS, 8, program counter / imem address width
INSTR_BITS, 16, instruction word width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low; top level drives it from the dispatcher's core_reset via inversion
start  in  1  block assignment valid; dispatcher holds high until it sees done
block_id  in  8  block index; latched on start
thread_count  in  $clog2(THREADS_PER_BLOCK)+1  live threads in block; latched on start
done  out  1  block finished; held until reset
thread_enable  out  THREADS_PER_BLOCK  per-thread active mask
latched_block_id  out  8  registered block_id for register files (%blockIdx)
core_state  out  3  current FSM state (state_t encoding)
pc  out  PC_BITS  current program counter
imem_req  out  1  instruction fetch request
imem_addr  out  PC_BITS  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_data  in  INSTR_BITS  fetched instruction
instruction  out  INSTR_BITS  latched instruction for decoder
decoded_mem  in  1  decoded instruction is LDR/STR
decoded_ret  in  1  decoded instruction is RET
branch_taken  in  1  evaluated in EXECUTE, valid in UPDATE
branch_target  in  PC_BITS  branch destination
lsu_req  out  1  one-cycle pulse: launch memory op on enabled threads
lsu_done  in  THREADS_PER_BLOCK  per-thread completion pulses

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; done=0; pc=0; thread_enable=0; latched_block_id=0; instruction=0; imem_req=0; lsu_req=0; pending mask=0.
  - Reset aborts any state, including mid-fetch and mid-WAIT.
- IDLE:
  - When start==1: latch block_id.
  - thread_enable = (1<<min(thread_count,THREADS_PER_BLOCK))-1, clamped.
  - pc=0.
  - thread_count==0 -> DONE; else -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ack.
  - On ack: instruction<=imem_data, imem_req<=0 -> DECODE.
  - imem_ack outside FETCH is ignored.
- DECODE: one cycle -> REQUEST. decoded_* are valid from REQUEST onward.
- REQUEST: one cycle.
  - If decoded_mem: lsu_req=1 for this cycle only, and pending<=thread_enable.
  - Else pending<=0.
  - -> WAIT.
- WAIT:
  - Each cycle, pending<=pending & ~lsu_done.
  - Exit to EXECUTE on the cycle pending==0 is observed (minimum one cycle in WAIT).
  - lsu_done bits for disabled threads are ignored. lsu_done in REQUEST is ignored; LSU latency is >=1 cycle.
- EXECUTE: one cycle -> UPDATE.
- UPDATE:
  - If decoded_ret -> DONE; pc unchanged.
  - Else pc <= branch_taken ? branch_target : pc+1, modulo 2^PC_BITS (0xFF wraps to 0x00); -> FETCH.
- DONE:
  - done=1; all outputs hold; imem_req=0, lsu_req=0.
  - Leaves only via reset. start deasserting here, or at any time after IDLE, is ignored.
- Latency, non-memory instruction, ack in first FETCH cycle: 6 cycles per instruction (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- Dispatch protocol: the dispatcher counts a block when start&&done, then pulses reset. The sequencer must never drop done before reset.

Decomposition:
- Shared package gpu_pkg:
  - state_t enum, 3 bits: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
  - THREADS_PER_BLOCK and PC_BITS defaults.
- Optional sub-module lsu_pending_tracker: pending mask set/clear logic and all_clear flag. The FSM stays in block_sequencer.

Test Plan:
- Reset/idle: reset=0 for 2 cycles with start=1 -> done=0, state=IDLE, thread_enable=0, imem_req=0. Release with start=1, thread_count=4 -> FETCH next cycle, thread_enable=4'b1111.
- Straight-line program: 3 ALU ops then RET, imem_ack same cycle -> pc 0,1,2,3, 6 cycles per instruction, done=1 after cycle 24, held with start still 1.
- Partial block and zero block:
  - thread_count=3 -> thread_enable=4'b0111.
  - thread_count=0 -> DONE one cycle after start, no imem_req ever.
- Memory op: LDR, enable=0111, lsu_done pulses thread0 @+2, thread2 @+5, thread1 @+9, bit3 spurious @+1 -> lsu_req exactly one cycle; WAIT exits only after thread1 done; bit3 ignored.
- Branch and wrap: branch_taken=1, target=0x10 -> pc=0x10. Non-branch at pc=0xFF -> pc=0x00. imem_ack delayed 3 cycles -> imem_req/imem_addr stable throughout.
- Mid-operation reset: reset=0 during WAIT with pending=0101 -> next cycle IDLE, pending=0, lsu_req=0. New start with block_id=7 -> latched_block_id=7, pc=0.
